// File: rtl/uart_bus_pkg.sv
// Shared definitions for the UART bus bridge: register offsets, STATUS/CTRL bit
// positions and FSM state encodings.
`timescale 1ns/1ps
package uart_bus_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_OVRCNT = 2'd3;

    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_RX_FULL     = 1;
    localparam int ST_TX_EMPTY    = 2;
    localparam int ST_TX_FULL     = 3;
    localparam int ST_TX_BUSY     = 4;
    localparam int ST_RX_OVF      = 5;
    localparam int ST_TX_OVF      = 6;
    localparam int ST_RX_COUNT    = 8;
    localparam int ST_TX_COUNT    = 16;

    localparam int CTRL_RX_IE = 0;
    localparam int CTRL_TX_IE = 1;

    typedef enum logic [1:0] {
        B_IDLE,
        B_ACK,
        B_WAIT
    } bus_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_BUSY
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; DEPTH must be a power of two.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_bus_bridge.sv
// Bus slave bridging word-wide register accesses to a byte-level UART core via TX/RX FIFOs.
// Define UART_BRIDGE_OVRCNT_EN to build the saturating dropped-byte counter at OVRCNT.
`timescale 1ns/1ps
module uart_bus_bridge
    import uart_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr_i,
    input  logic [31:0] bus_data_i,
    output logic [31:0] bus_data_o,
    input  logic [1:0]  bus_sel_i,
    input  logic        bus_rd_i,
    input  logic        bus_we_i,
    output logic        bus_ack_o,
    output logic [7:0]  uart_data_in,
    output logic        uart_data_send,
    input  logic        uart_data_sent,
    input  logic [7:0]  uart_data_out,
    input  logic        uart_data_received,
    output logic        irq
);

    bus_state_t bus_state_reg, bus_state_next;
    tx_state_t  tx_state_reg, tx_state_next;

    logic [1:0]       ctrl_reg;
    logic             rx_ovf_reg;
    logic             tx_ovf_reg;
    logic             access;
    logic             wr_access;
    logic             rd_access;
    logic [1:0]       reg_sel;
    logic             ctrl_we;
    logic             rx_full, rx_empty, tx_full, tx_empty;
    logic [FIFO_AW:0] rx_count, tx_count;
    logic [7:0]       rx_dout, tx_dout;
    logic             rx_pop, tx_push, tx_pop;
    logic             rx_drop, tx_drop;
    logic             tx_busy;
    logic [31:0]      status;
    logic [31:0]      read_value;
    logic [15:0]      ovr_value;
    logic             unused_bits;

    assign unused_bits = ^{bus_sel_i, bus_addr_i[31:4], bus_addr_i[1:0], bus_data_i[31:8]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (uart_data_received),
        .pop   (rx_pop),
        .din   (uart_data_out),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (bus_data_i[7:0]),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    // The access happens only on the IDLE->ACK transition, so a held request pops/pushes once.
    always_comb begin
        bus_state_next = bus_state_reg;
        access         = 1'b0;
        case (bus_state_reg)
            B_IDLE: begin
                if (bus_rd_i || bus_we_i) begin
                    access         = 1'b1;
                    bus_state_next = B_ACK;
                end
            end
            B_ACK:  bus_state_next = B_WAIT;
            B_WAIT: begin
                if (!bus_rd_i && !bus_we_i) begin
                    bus_state_next = B_IDLE;
                end
            end
            default: bus_state_next = B_IDLE;
        endcase
    end

    assign reg_sel   = bus_addr_i[3:2];
    assign wr_access = access & bus_we_i;
    assign rd_access = access & ~bus_we_i;
    assign rx_pop    = rd_access & (reg_sel == REG_DATA) & ~rx_empty;
    assign tx_push   = wr_access & (reg_sel == REG_DATA);
    assign ctrl_we   = wr_access & (reg_sel == REG_CTRL);
    assign tx_drop   = tx_push & tx_full & ~tx_pop;
    assign rx_drop   = uart_data_received & rx_full & ~rx_pop;
    assign tx_busy   = (tx_state_reg == TX_BUSY);
    assign bus_ack_o = (bus_state_reg == B_ACK);

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_pop        = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop        = 1'b1;
                    tx_state_next = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (uart_data_sent) begin
                    tx_state_next = TX_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        status                               = '0;
        status[ST_RX_NONEMPTY]               = ~rx_empty;
        status[ST_RX_FULL]                   = rx_full;
        status[ST_TX_EMPTY]                  = tx_empty;
        status[ST_TX_FULL]                   = tx_full;
        status[ST_TX_BUSY]                   = tx_busy;
        status[ST_RX_OVF]                    = rx_ovf_reg;
        status[ST_TX_OVF]                    = tx_ovf_reg;
        status[ST_RX_COUNT +: FIFO_AW+1]     = rx_count;
        status[ST_TX_COUNT +: FIFO_AW+1]     = tx_count;
    end

    always_comb begin
        read_value = '0;
        case (reg_sel)
            REG_DATA: begin
                if (!rx_empty) begin
                    read_value[7:0] = rx_dout;
                end
            end
            REG_STATUS: read_value       = status;
            REG_CTRL:   read_value[1:0]  = ctrl_reg;
            REG_OVRCNT: read_value[15:0] = ovr_value;
            default:    read_value       = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_state_reg  <= B_IDLE;
            tx_state_reg   <= TX_IDLE;
            bus_data_o     <= '0;
            uart_data_in   <= '0;
            uart_data_send <= 1'b0;
            irq            <= 1'b0;
            ctrl_reg       <= '0;
            rx_ovf_reg     <= 1'b0;
            tx_ovf_reg     <= 1'b0;
        end else begin
            bus_state_reg  <= bus_state_next;
            tx_state_reg   <= tx_state_next;
            bus_data_o     <= rd_access ? read_value : '0;
            uart_data_send <= tx_pop;
            if (tx_pop) begin
                uart_data_in <= tx_dout;
            end
            irq <= (ctrl_reg[CTRL_RX_IE] & ~rx_empty)
                 | (ctrl_reg[CTRL_TX_IE] & tx_empty & ~tx_busy);
            if (ctrl_we) begin
                ctrl_reg <= bus_data_i[1:0];
            end
            // A new drop wins over a same-cycle clear so the event is never lost.
            if (rx_drop) begin
                rx_ovf_reg <= 1'b1;
            end else if (ctrl_we && bus_data_i[ST_RX_OVF]) begin
                rx_ovf_reg <= 1'b0;
            end
            if (tx_drop) begin
                tx_ovf_reg <= 1'b1;
            end else if (ctrl_we && bus_data_i[ST_TX_OVF]) begin
                tx_ovf_reg <= 1'b0;
            end
        end
    end

`ifdef UART_BRIDGE_OVRCNT_EN
    logic [15:0] ovr_cnt_reg;
    logic [16:0] ovr_sum;
    logic        ovr_we;

    assign ovr_we  = wr_access & (reg_sel == REG_OVRCNT);
    assign ovr_sum = {1'b0, ovr_cnt_reg} + {16'b0, rx_drop} + {16'b0, tx_drop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_cnt_reg <= '0;
        end else if (ovr_we) begin
            ovr_cnt_reg <= '0;
        end else if (ovr_sum[16]) begin
            ovr_cnt_reg <= 16'hFFFF;
        end else begin
            ovr_cnt_reg <= ovr_sum[15:0];
        end
    end

    assign ovr_value = ovr_cnt_reg;
`else
    assign ovr_value = '0;
`endif

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge: a register-access vector table followed by
// hand-written TX handshake, RX overflow, held-request and interrupt sequences.
`timescale 1ns/1ps
module tb_uart_bus_bridge;
    import uart_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bus_addr_i;
    logic [31:0] bus_data_i;
    logic [31:0] bus_data_o;
    logic [1:0]  bus_sel_i;
    logic        bus_rd_i;
    logic        bus_we_i;
    logic        bus_ack_o;
    logic [7:0]  uart_data_in;
    logic        uart_data_send;
    logic        uart_data_sent;
    logic [7:0]  uart_data_out;
    logic        uart_data_received;
    logic        irq;

    int          total = 0;
    int          passed = 0;
    int unsigned cyc = 0;
    logic [7:0]  send_bytes[$];
    int unsigned send_cyc[$];
    int          send_wide = 0;
    logic        prev_send = 1'b0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    vec_t        vecs[11];
    logic [31:0] rdata;
    int          n0;
    int unsigned sent_at;
    int          acks;
    logic [31:0] held_data;
    logic [31:0] exp_ovr;

    always #5 clk = ~clk;

    uart_bus_bridge #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .bus_addr_i         (bus_addr_i),
        .bus_data_i         (bus_data_i),
        .bus_data_o         (bus_data_o),
        .bus_sel_i          (bus_sel_i),
        .bus_rd_i           (bus_rd_i),
        .bus_we_i           (bus_we_i),
        .bus_ack_o          (bus_ack_o),
        .uart_data_in       (uart_data_in),
        .uart_data_send     (uart_data_send),
        .uart_data_sent     (uart_data_sent),
        .uart_data_out      (uart_data_out),
        .uart_data_received (uart_data_received),
        .irq                (irq)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Records every send strobe and counts strobes wider than one cycle.
    always @(posedge clk) begin
        #1;
        if (uart_data_send) begin
            if (prev_send) send_wide++;
            else begin
                send_bytes.push_back(uart_data_in);
                send_cyc.push_back(cyc);
            end
        end
        prev_send = uart_data_send;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rd);
        logic got_ack = 1'b0;
        bus_addr_i = addr;
        bus_data_i = wdata;
        bus_sel_i  = 2'b11;
        bus_we_i   = we;
        bus_rd_i   = ~we;
        rd         = '0;
        for (int i = 0; i < 10 && !got_ack; i++) begin
            tick(1);
            if (bus_ack_o) begin
                got_ack = 1'b1;
                rd      = bus_data_o;
            end
        end
        bus_rd_i = 1'b0;
        bus_we_i = 1'b0;
        if (!got_ack) check("ack timeout", {31'b0, got_ack}, 32'd1);
        tick(2);
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] d);
        logic [31:0] dummy;
        bus_xfer(1'b1, {28'b0, r, 2'b00}, d, dummy);
    endtask

    task automatic rd_reg(input logic [1:0] r, output logic [31:0] d);
        bus_xfer(1'b0, {28'b0, r, 2'b00}, 32'h0, d);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        uart_data_out      = b;
        uart_data_received = 1'b1;
        tick(1);
        uart_data_received = 1'b0;
    endtask

    task automatic pulse_sent(output int unsigned at);
        uart_data_sent = 1'b1;
        tick(1);
        at = cyc;
        uart_data_sent = 1'b0;
    endtask

    task automatic wait_sends(input int n, input int limit);
        int i = 0;
        while (send_bytes.size() < n && i < limit) begin
            tick(1);
            i++;
        end
        if (send_bytes.size() < n) check("send pulse timeout", send_bytes.size(), n);
    endtask

    initial begin
        rst = 1'b1;
        bus_addr_i = '0; bus_data_i = '0; bus_sel_i = '0; bus_rd_i = 1'b0; bus_we_i = 1'b0;
        uart_data_sent = 1'b0; uart_data_out = '0; uart_data_received = 1'b0;

        vecs[0]  = '{1'b0, 32'h0000_0004, 32'h0,        32'h0000_0004, 1'b0};
        vecs[1]  = '{1'b0, 32'hFFFF_FFF4, 32'h0,        32'h0000_0004, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0000, 32'h0,        32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0008, 32'h0000_0003, 32'h0,        1'b1};
        vecs[4]  = '{1'b0, 32'h0000_0008, 32'h0,        32'h0000_0003, 1'b1};
        vecs[5]  = '{1'b0, 32'h0000_000C, 32'h0,        32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 32'h0000_000C, 32'h0,        32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b1, 32'h0000_0008, 32'h0000_0001, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0008, 32'h0,        32'h0000_0001, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_0008, 32'h0000_0000, 32'h0,        1'b0};

        tick(3);
        check("reset irq", {31'b0, irq}, 32'd0);
        check("reset ack", {31'b0, bus_ack_o}, 32'd0);
        check("reset rdata", bus_data_o, 32'd0);
        rst = 1'b0;
        tick(3);
        check("no send after reset", send_bytes.size(), 32'd0);

        // Register-access table
        for (int i = 0; i < 11; i++) begin
            bus_xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, rdata);
            if (!vecs[i].we) check($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
        end
        $display("table: %0d register vectors applied", 11);

        // TX handshake: second byte must wait for data_sent
        n0 = send_bytes.size();
        wr(REG_DATA, 32'h41);
        wr(REG_DATA, 32'h42);
        wait_sends(n0 + 1, 50);
        tick(20);
        check("one send before data_sent", send_bytes.size(), n0 + 1);
        pulse_sent(sent_at);
        wait_sends(n0 + 2, 50);
        check("send byte 0", {24'b0, send_bytes[n0]}, 32'h41);
        check("send byte 1", {24'b0, send_bytes[n0+1]}, 32'h42);
        check("send 1 after data_sent", {31'b0, send_cyc[n0+1] > sent_at}, 32'd1);
        check("send width", send_wide, 32'd0);
        tick(20);
        pulse_sent(sent_at);
        tick(2);
        rd_reg(REG_STATUS, rdata);
        check("status after tx", rdata, 32'h0000_0004);
        $display("tx: two bytes sent");

        // RX overflow on the 17th byte
        for (int i = 0; i < 16; i++) rx_byte(8'(i));
        rx_byte(8'hAA);
        rd_reg(REG_STATUS, rdata);
        check("status rx full+ovf", rdata, 32'h0000_1027);
        for (int i = 0; i < 16; i++) begin
            rd_reg(REG_DATA, rdata);
            check($sformatf("rx read %0d", i), rdata, 32'(i));
        end
        rd_reg(REG_DATA, rdata);
        check("rx read empty", rdata, 32'h0);
        rd_reg(REG_STATUS, rdata);
        check("status rx drained", rdata, 32'h0000_0024);
        $display("rx: 16 bytes read, overflow flagged");

        // Read request held for 5 cycles
        rx_byte(8'h55);
        rx_byte(8'h66);
        acks = 0;
        held_data = '0;
        bus_addr_i = 32'h0; bus_we_i = 1'b0; bus_rd_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (bus_ack_o) begin
                acks++;
                held_data = bus_data_o;
            end
        end
        check("held read rdata idle", bus_data_o, 32'h0);
        bus_rd_i = 1'b0;
        tick(2);
        check("held read acks", acks, 32'd1);
        check("held read data", held_data, 32'h55);
        rd_reg(REG_STATUS, rdata);
        check("status after held read", rdata, 32'h0000_0125);
        rd_reg(REG_DATA, rdata);
        check("read second byte", rdata, 32'h66);
        $display("held read: %0d ack", acks);

        // RX interrupt timing
        wr(REG_CTRL, 32'h1);
        check("irq idle rx_ie", {31'b0, irq}, 32'd0);
        rx_byte(8'h7E);
        check("irq push cycle", {31'b0, irq}, 32'd0);
        tick(1);
        check("irq after push", {31'b0, irq}, 32'd1);
        bus_addr_i = 32'h0; bus_we_i = 1'b0; bus_rd_i = 1'b1;
        tick(1);
        check("irq read ack", {31'b0, bus_ack_o}, 32'd1);
        check("irq read data", bus_data_o, 32'h7E);
        check("irq at pop+1", {31'b0, irq}, 32'd1);
        bus_rd_i = 1'b0;
        tick(1);
        check("irq falls", {31'b0, irq}, 32'd0);
        tick(1);
        $display("irq: rx interrupt sequence done");

        // TX overflow, OVRCNT and flag clearing
        wr(REG_OVRCNT, 32'h0);
        n0 = send_bytes.size();
        for (int i = 0; i < 20; i++) wr(REG_DATA, 32'h80 + 32'(i));
`ifdef UART_BRIDGE_OVRCNT_EN
        exp_ovr = 32'd3;
`else
        exp_ovr = 32'd0;
`endif
        rd_reg(REG_OVRCNT, rdata);
        check("ovrcnt after tx drops", rdata, exp_ovr);
        check("tx launches while busy", send_bytes.size(), n0 + 1);
        rd_reg(REG_STATUS, rdata);
        check("status tx full+ovf", rdata, 32'h0010_0078);
        wr(REG_CTRL, 32'h60);
        rd_reg(REG_STATUS, rdata);
        check("status ovf cleared", rdata, 32'h0010_0018);
        rd_reg(REG_CTRL, rdata);
        check("ctrl after clear", rdata, 32'h0);
        wr(REG_OVRCNT, 32'h1234);
        rd_reg(REG_OVRCNT, rdata);
        check("ovrcnt cleared", rdata, 32'h0);
        $display("tx overflow: %0d drops expected in counter", exp_ovr);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
